spi_mmio_bridge: RTL
====================

Name: spi_mmio_bridge

Overview:
- Memory-mapped front-end that sits directly upstream of the byte-level SPI engine.
- CPU writes bytes into a TX FIFO. A sequencer hands them one at a time to the engine and pushes each received byte into an RX FIFO for the CPU to read.
- Also owns the engine's configuration: clock divider, mode and enable.

Parameters:
- FIFO_DEPTH, 4, entries per FIFO (power of 2, ≥2)
- CLKDIV_RESET, 4, reset value of the CLKDIV register

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_addr  in  3  word address: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL, 4 CLKDIV; others unmapped
- bus_wen  in  1  write strobe, one cycle per write
- bus_ren  in  1  read strobe, one cycle per read
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, combinational from bus_addr
- clkdiv  out  32  divider value to engine
- spi_mode  out  2  CTRL[2:1]
- spi_enable  out  1  high only while a byte is in flight
- spi_data_out  out  8  byte to transmit
- data_out_ready  out  1  one-cycle load pulse to engine
- spi_data_in  in  8  byte received by engine
- data_in_ready  in  1  byte-complete flag from engine (level, may stay high)
- irq  out  1  high while (CTRL[4] & !rx_empty) | rx_overflow

Behaviour:
- Reset values:
  - Outputs: all 0 except clkdiv=CLKDIV_RESET.
  - FIFOs empty, sticky flags clear, FSM in IDLE.
- Register map, reads:
  - TXDATA reads 0.
  - RXDATA returns {24'b0, rx head}; 0 when empty.
  - STATUS = {25'b0, tx_ovf, rx_ovf, busy, rx_empty, rx_full, tx_empty, tx_full}.
  - CTRL = {27'b0, irq_en, flush, mode[1:0], enable}; flush reads 0.
  - CLKDIV full 32 bits. Unmapped addresses read 0.
- Register map, side effects:
  - Write TXDATA: push bus_wdata[7:0].
  - Read RXDATA (bus_ren): pop head if not empty.
  - Write STATUS: bit5=1 clears rx_ovf; bit6=1 clears tx_ovf (W1C).
  - Write CTRL bit3=1: flushes both FIFOs this cycle. Any pending push/pop in the same cycle is ignored. Sticky flags unchanged.
- FIFO rules:
  - Full/empty use pointer+extra-bit compare.
  - Write to TXDATA while tx_full: data dropped, tx_ovf set. Applies even if the sequencer pops the same cycle, because full is sampled pre-pop.
  - RX push while rx_full: byte dropped, rx_ovf set.
  - Simultaneous push and pop on a non-full, non-empty FIFO: both occur, count unchanged.
- Sequencer FSM:
  - IDLE:
    - Move to LOAD when enable=1 and tx not empty.
  - LOAD (1 cycle):
    - Pop TX head into spi_data_out register.
    - data_out_ready=1 and spi_enable=1.
    - Go to WAIT.
  - WAIT:
    - spi_enable=1, data_out_ready=0.
    - Capture data_in_ready into a register each cycle.
    - On a rising edge (current=1, previous=0): push spi_data_in to RX, go to DONE.
    - If enable cleared or flush written: abort to IDLE. spi_enable drops next cycle, no RX push.
  - DONE (1 cycle):
    - spi_enable=0, return to IDLE.
    - Guarantees ≥1 idle cycle between bytes, so back-to-back transfer latency is 3 cycles + engine time.
- busy = (state != IDLE) | !tx_empty.
- CLKDIV/mode writes take effect immediately. Software changes them only when busy=0; behaviour mid-byte is unspecified.
- Asynchronous reset mid-transfer: immediate return to reset state, bytes in flight lost.

Test Plan:
- Single byte: write CLKDIV=2, CTRL=0x1, TXDATA=0xA5; engine model answers 0x3C.
  → exactly one data_out_ready pulse with spi_data_out=0xA5; RXDATA reads 0x3C; STATUS then reads 0x0A (both empty).
- Burst/full: CTRL=0 (disabled), write 5 bytes 0x01..0x05 with FIFO_DEPTH=4.
  → STATUS tx_full=1 and tx_ovf=1. Enable → engine sees 0x01..0x04 in order. Write STATUS=0x40 → tx_ovf clears.
- RX overflow: send 5 bytes without reading RXDATA.
  → rx_full=1, rx_ovf=1, irq=1. Reads return the first 4 responses in order, then 0 with rx_empty=1.
- Level data_in_ready: engine holds data_in_ready high for 10 cycles.
  → exactly one RX push per byte.
- Abort: clear CTRL.enable during WAIT.
  → spi_enable low within 1 cycle, no RX push, remaining TX bytes retained. Re-enable resumes with the next byte.
- Flush and reset: fill both FIFOs, write CTRL=0x9.
  → both empty, overflow flags unchanged. Assert reset mid-WAIT → all outputs at reset values, clkdiv=4.

Source files
------------

// File: rtl/spi_mmio_bridge.sv
`timescale 1ns/1ps
// Memory-mapped front-end for the byte-level SPI engine: register file, TX/RX
// byte FIFOs and a sequencer that hands one byte at a time to the engine.
module spi_mmio_bridge #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] CLKDIV_RESET = 32'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  bus_addr,
    input  logic        bus_wen,
    input  logic        bus_ren,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [31:0] clkdiv,
    output logic [1:0]  spi_mode,
    output logic        spi_enable,
    output logic [7:0]  spi_data_out,
    output logic        data_out_ready,
    input  logic [7:0]  spi_data_in,
    input  logic        data_in_ready,
    output logic        irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_e;

    state_e      state_q, state_d;
    ptr_t        tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [31:0] clkdiv_q;
    logic [1:0]  mode_q;
    logic [7:0]  data_out_q;
    logic        enable_q, irq_en_q, tx_ovf_q, rx_ovf_q, din_prev_q;

    logic wr_tx, rd_rx, wr_status, wr_ctrl, wr_clkdiv, flush, enable_now;
    logic tx_full, tx_empty, rx_full, rx_empty, busy;
    logic din_edge, abort, rx_push_req, tx_push, tx_pop, rx_push, rx_pop, start;

    assign wr_tx     = bus_wen && (bus_addr == 3'd0);
    assign rd_rx     = bus_ren && (bus_addr == 3'd1);
    assign wr_status = bus_wen && (bus_addr == 3'd2);
    assign wr_ctrl   = bus_wen && (bus_addr == 3'd3);
    assign wr_clkdiv = bus_wen && (bus_addr == 3'd4);
    assign flush     = wr_ctrl && bus_wdata[3];
    // A CTRL write clearing enable aborts in the same cycle it is written.
    assign enable_now = wr_ctrl ? bus_wdata[0] : enable_q;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign busy     = (state_q != S_IDLE) || !tx_empty;

    assign din_edge    = data_in_ready && !din_prev_q;
    assign abort       = !enable_now || flush;
    assign rx_push_req = (state_q == S_WAIT) && !abort && din_edge;
    assign tx_push     = wr_tx && !tx_full && !flush;
    assign tx_pop      = (state_q == S_LOAD) && !tx_empty && !flush;
    assign rx_push     = rx_push_req && !rx_full;
    assign rx_pop      = rd_rx && !rx_empty && !flush;
    assign start       = (state_q == S_IDLE) && (state_d == S_LOAD);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable_now && !tx_empty && !flush) state_d = S_LOAD;
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (abort)         state_d = S_IDLE;
                else if (din_edge) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        spi_enable     = 1'b0;
        data_out_ready = 1'b0;
        case (state_q)
            S_LOAD: begin
                spi_enable     = 1'b1;
                data_out_ready = 1'b1;
            end
            S_WAIT:  spi_enable = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            clkdiv_q   <= CLKDIV_RESET;
            mode_q     <= 2'b00;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            din_prev_q <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (flush) begin
                tx_wptr_q <= '0;
                tx_rptr_q <= '0;
                rx_wptr_q <= '0;
                rx_rptr_q <= '0;
            end else begin
                if (tx_push) tx_wptr_q <= tx_wptr_q + ptr_t'(1);
                if (tx_pop)  tx_rptr_q <= tx_rptr_q + ptr_t'(1);
                if (rx_push) rx_wptr_q <= rx_wptr_q + ptr_t'(1);
                if (rx_pop)  rx_rptr_q <= rx_rptr_q + ptr_t'(1);
            end
            if (wr_tx && tx_full && !flush)       tx_ovf_q <= 1'b1;
            else if (wr_status && bus_wdata[6])   tx_ovf_q <= 1'b0;
            if (rx_push_req && rx_full)           rx_ovf_q <= 1'b1;
            else if (wr_status && bus_wdata[5])   rx_ovf_q <= 1'b0;
            if (wr_ctrl) begin
                enable_q <= bus_wdata[0];
                mode_q   <= bus_wdata[2:1];
                irq_en_q <= bus_wdata[4];
            end
            if (wr_clkdiv)            clkdiv_q   <= bus_wdata;
            if (state_q == S_WAIT)    din_prev_q <= data_in_ready;
            if (start)                data_out_q <= tx_mem[tx_rptr_q[AW-1:0]];
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= bus_wdata[7:0];
        if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= spi_data_in;
    end

    always_comb begin
        bus_rdata = 32'h0;
        case (bus_addr)
            3'd1: if (!rx_empty) bus_rdata = {24'h0, rx_mem[rx_rptr_q[AW-1:0]]};
            3'd2: bus_rdata = {25'h0, tx_ovf_q, rx_ovf_q, busy, rx_empty, rx_full,
                               tx_empty, tx_full};
            3'd3: bus_rdata = {27'h0, irq_en_q, 1'b0, mode_q, enable_q};
            3'd4: bus_rdata = clkdiv_q;
            default: bus_rdata = 32'h0;
        endcase
    end

    assign clkdiv       = clkdiv_q;
    assign spi_mode     = mode_q;
    assign spi_data_out = data_out_q;
    assign irq          = (irq_en_q && !rx_empty) || rx_ovf_q;

endmodule
